baccarat_deal_ctrl: RTL

BACCARAT_DEAL_CTRL -- requirements
Module: baccarat_deal_ctrl

---
 rtl/baccarat_deal_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/baccarat_deal_ctrl.sv
// Baccarat dealing sequencer: strobes card loads, applies the third-card
// rules and latches the win lights. Optional DEAL_STEP_EN adds a step gate.
module baccarat_deal_ctrl (
    input  logic       slow_clock,
    input  logic       resetb,
`ifdef DEAL_STEP_EN
    input  logic       step,
`endif
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       hand_done
);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        P1    = 4'd1,
        D1    = 4'd2,
        P2    = 4'd3,
        D2    = 4'd4,
        EVAL1 = 4'd5,
        P3    = 4'd6,
        EVAL2 = 4'd7,
        D3    = 4'd8,
        SCORE = 4'd9,
        DONE  = 4'd10
    } state_t;

    state_t     state_q, state_d;
    logic       pwin_q, pwin_d;
    logic       dwin_q, dwin_d;
    logic       adv;
    logic [3:0] pv;
    logic       d3_draw;

`ifdef DEAL_STEP_EN
    assign adv = step;
`else
    assign adv = 1'b1;
`endif

    // Face cards and tens count as zero for the dealer's third-card rule.
    assign pv = (pcard3 >= 4'd1 && pcard3 <= 4'd9) ? pcard3 : 4'd0;

    // Dealer third-card table, keyed on dealer score and player's third card.
    always_comb begin
        d3_draw = 1'b0;
        unique case (1'b1)
            (dscore <= 4'd2): d3_draw = 1'b1;
            (dscore == 4'd3): d3_draw = (pv != 4'd8);
            (dscore == 4'd4): d3_draw = (pv >= 4'd2 && pv <= 4'd7);
            (dscore == 4'd5): d3_draw = (pv >= 4'd4 && pv <= 4'd7);
            (dscore == 4'd6): d3_draw = (pv >= 4'd6 && pv <= 4'd7);
            default:          d3_draw = 1'b0;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge slow_clock) begin
        if (!resetb) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; every move waits for adv, DONE never leaves.
    always_comb begin
        state_d = state_q;
        if (adv) begin
            unique case (state_q)
                IDLE:  state_d = P1;
                P1:    state_d = D1;
                D1:    state_d = P2;
                P2:    state_d = D2;
                D2:    state_d = EVAL1;
                EVAL1: begin
                    if (pscore >= 4'd8 || dscore >= 4'd8) state_d = SCORE;
                    else if (pscore <= 4'd5)             state_d = P3;
                    else if (dscore <= 4'd5)             state_d = D3;
                    else                                 state_d = SCORE;
                end
                P3:    state_d = EVAL2;
                EVAL2: state_d = d3_draw ? D3 : SCORE;
                D3:    state_d = SCORE;
                SCORE: state_d = DONE;
                DONE:  state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Strobes decode from state, suppressed while reset is asserted.
    always_comb begin
        load_pcard1 = 1'b0;
        load_pcard2 = 1'b0;
        load_pcard3 = 1'b0;
        load_dcard1 = 1'b0;
        load_dcard2 = 1'b0;
        load_dcard3 = 1'b0;
        hand_done   = (state_q == DONE);
        if (resetb && adv) begin
            unique case (state_q)
                P1:      load_pcard1 = 1'b1;
                P2:      load_pcard2 = 1'b1;
                P3:      load_pcard3 = 1'b1;
                D1:      load_dcard1 = 1'b1;
                D2:      load_dcard2 = 1'b1;
                D3:      load_dcard3 = 1'b1;
                default: ;
            endcase
        end
    end

    // Win lights compare final scores on the SCORE->DONE transition.
    always_comb begin
        pwin_d = pwin_q;
        dwin_d = dwin_q;
        if (state_q == SCORE && adv) begin
            pwin_d = (pscore >= dscore);
            dwin_d = (dscore >= pscore);
        end
    end

    // Light registers, cleared by reset and held through DONE.
    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            pwin_q <= 1'b0;
            dwin_q <= 1'b0;
        end else begin
            pwin_q <= pwin_d;
            dwin_q <= dwin_d;
        end
    end

    assign player_win_light = pwin_q;
    assign dealer_win_light = dwin_q;

endmodule
